// File: rtl/muldiv_sequencer_if.sv
// Issue/readback bundle between the execute stage and the HI/LO multiply-divide unit.
// The master side issues operations and reads HI/LO; the slave side is the unit itself.
interface muldiv_sequencer_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        kill;
    logic        rd_req;
    logic        rd_sel;
    logic [31:0] rd_data;
    logic        busy;
    logic        stall;
    logic        done;

    modport master (
        output start, op, src_a, src_b, kill, rd_req, rd_sel,
        input  rd_data, busy, stall, done
    );

    modport slave (
        input  start, op, src_a, src_b, kill, rd_req, rd_sel,
        output rd_data, busy, stall, done
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// HI/LO unit for the MIPS core: radix-2^MUL_BITS shift-add multiplier, restoring divider,
// sign fix-up and multiply-accumulate, with pipeline stall generation.
module muldiv_sequencer #(
    parameter int MUL_BITS = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    muldiv_sequencer_if.slave  bus
);
    localparam int N_MUL = 32 / MUL_BITS;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_ACC  = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic [5:0]  r_cnt;
    logic        r_is_mul;
    logic        r_acc;
    logic        r_neg_res;
    logic        r_neg_rem;
    logic        r_div0;
    logic [31:0] r_a_raw;
    logic [63:0] r_mcand;
    logic [31:0] r_mplier;
    logic [63:0] r_prod;
    logic [31:0] r_rem;
    logic [31:0] r_quot;
    logic [31:0] r_divisor;

    logic        w_accept;
    logic        w_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [63:0] w_pp [MUL_BITS];
    logic [63:0] w_pp_sum;
    logic [63:0] w_prod_fix;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_diff;
    logic [31:0] w_rem_next;
    logic [31:0] w_quot_fix;
    logic [31:0] w_rem_fix;

    assign w_accept = bus.start & ~r_busy & ~bus.kill;
    // MULT, MADD and DIV have op[0]==0; they work on magnitudes and fix the sign afterwards.
    assign w_signed = ~bus.op[0];
    assign w_mag_a  = (w_signed && bus.src_a[31]) ? (32'd0 - bus.src_a) : bus.src_a;
    assign w_mag_b  = (w_signed && bus.src_b[31]) ? (32'd0 - bus.src_b) : bus.src_b;

    // One partial product per retired multiplier bit; r_mcand is pre-shifted to the digit position.
    generate
        for (genvar gi = 0; gi < MUL_BITS; gi++) begin : g_pp
            assign w_pp[gi] = r_mplier[gi] ? (r_mcand << gi) : 64'd0;
        end
    endgenerate

    always_comb begin
        w_pp_sum = 64'd0;
        for (int k = 0; k < MUL_BITS; k++) begin
            w_pp_sum = w_pp_sum + w_pp[k];
        end
    end

    // Restoring step: the partial remainder is always below the divisor, so the
    // difference fits in 32 bits whenever the shifted value is not smaller.
    assign w_shift    = {r_rem, r_quot[31]};
    assign w_ge       = w_shift[32] | (w_shift[31:0] >= r_divisor);
    assign w_diff     = w_shift[31:0] - r_divisor;
    assign w_rem_next = w_ge ? w_diff : w_shift[31:0];

    assign w_prod_fix = r_neg_res ? (64'd0 - r_prod) : r_prod;
    assign w_quot_fix = r_neg_res ? (32'd0 - r_quot) : r_quot;
    assign w_rem_fix  = r_neg_rem ? (32'd0 - r_rem)  : r_rem;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cnt     <= 6'd0;
            r_is_mul  <= 1'b0;
            r_acc     <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_div0    <= 1'b0;
            r_a_raw   <= 32'd0;
            r_mcand   <= 64'd0;
            r_mplier  <= 32'd0;
            r_prod    <= 64'd0;
            r_rem     <= 32'd0;
            r_quot    <= 32'd0;
            r_divisor <= 32'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (bus.op[2:1])
                            2'b11: begin
                                if (bus.op[0]) r_lo <= bus.src_a;
                                else           r_hi <= bus.src_a;
                            end
                            2'b10: begin
                                r_state   <= S_DIV;
                                r_busy    <= 1'b1;
                                r_is_mul  <= 1'b0;
                                r_acc     <= 1'b0;
                                r_cnt     <= 6'd0;
                                r_quot    <= w_mag_a;
                                r_divisor <= w_mag_b;
                                r_rem     <= 32'd0;
                                r_a_raw   <= bus.src_a;
                                r_div0    <= (bus.src_b == 32'd0);
                                r_neg_res <= w_signed & (bus.src_a[31] ^ bus.src_b[31]);
                                r_neg_rem <= w_signed & bus.src_a[31];
                            end
                            default: begin
                                r_state   <= S_MUL;
                                r_busy    <= 1'b1;
                                r_is_mul  <= 1'b1;
                                r_acc     <= bus.op[1];
                                r_cnt     <= 6'd0;
                                r_mcand   <= {32'd0, w_mag_a};
                                r_mplier  <= w_mag_b;
                                r_prod    <= 64'd0;
                                r_neg_res <= w_signed & (bus.src_a[31] ^ bus.src_b[31]);
                                r_neg_rem <= 1'b0;
                            end
                        endcase
                    end
                end
                S_MUL: begin
                    r_prod   <= r_prod + w_pp_sum;
                    r_mcand  <= r_mcand << MUL_BITS;
                    r_mplier <= r_mplier >> MUL_BITS;
                    r_cnt    <= r_cnt + 6'd1;
                    if (r_cnt == 6'(N_MUL - 1)) r_state <= S_FIX;
                end
                S_DIV: begin
                    r_rem  <= w_rem_next;
                    r_quot <= {r_quot[30:0], w_ge};
                    r_cnt  <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_mul && r_acc) begin
                        r_prod  <= w_prod_fix;
                        r_state <= S_ACC;
                    end else begin
                        if (r_is_mul) begin
                            {r_hi, r_lo} <= w_prod_fix;
                        end else if (r_div0) begin
                            r_lo <= 32'hFFFF_FFFF;
                            r_hi <= r_a_raw;
                        end else begin
                            r_lo <= w_quot_fix;
                            r_hi <= w_rem_fix;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_ACC: begin
                    {r_hi, r_lo} <= {r_hi, r_lo} + r_prod;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data = bus.rd_sel ? r_hi : r_lo;
    assign bus.busy    = r_busy;
    assign bus.stall   = r_busy & (bus.start | bus.rd_req);
    assign bus.done    = r_done;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer (MUL_BITS=4): latency, HI/LO results, stalls,
// kill, MTHI/MTLO, divide corner cases and asynchronous reset mid-operation.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_sequencer_if bus();

    muldiv_sequencer #(.MUL_BITS(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MADD  = 3'b010;
    localparam logic [2:0] OP_MADDU = 3'b011;
    localparam logic [2:0] OP_DIV   = 3'b100;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        bus.rd_sel = 1'b1;
        #1 hi = bus.rd_data;
        bus.rd_sel = 1'b0;
        #1 lo = bus.rd_data;
    endtask

    // Issue one multi-cycle op and check busy length, single done pulse and the final {HI,LO}.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc, input logic [63:0] exp_hilo);
        int cyc;
        int dones;
        logic [31:0] hi;
        logic [31:0] lo;
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        dones = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            cyc++;
            if (bus.done === 1'b1) dones++;
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_done_during_busy"}, 64'(dones), 64'd0);
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd1);
        read_hilo(hi, lo);
        check({tag, "_hilo"}, {hi, lo}, exp_hilo);
        @(negedge clk);
        check({tag, "_done_cleared"}, 64'(bus.done), 64'd0);
        $display("op %s a=0x%08h b=0x%08h busy=%0d HI=0x%08h LO=0x%08h", tag, a, b, cyc, hi, lo);
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] a, input logic k);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.src_a = a; bus.kill = k;
        @(negedge clk);
        bus.start = 1'b0; bus.kill = 1'b0;
        $display("mt op=%0d a=0x%08h kill=%0d busy=%0d", o, a, k, bus.busy);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] hi;
        logic [31:0] lo;
        int cyc;
        int bad;

        bus.start = 1'b0; bus.op = 3'd0; bus.src_a = 32'd0; bus.src_b = 32'd0;
        bus.kill = 1'b0; bus.rd_req = 1'b0; bus.rd_sel = 1'b0;

        // Reset state
        #2;
        read_hilo(hi, lo);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        bus.start = 1'b1;
        #1 check("rst_stall_idle", 64'(bus.stall), 64'd0);
        bus.start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        run_op("MULT_m3x7",  OP_MULT,  32'hFFFF_FFFD, 32'd7,        9, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("MULTU_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 9, 64'hFFFF_FFFE_0000_0001);

        mt(OP_MTHI, 32'd0, 1'b0);
        mt(OP_MTLO, 32'hFFFF_FFFF, 1'b0);
        run_op("MADDU_1x1",  OP_MADDU, 32'd1, 32'd1,                10, 64'h0000_0001_0000_0000);

        mt(OP_MTHI, 32'd0, 1'b0);
        mt(OP_MTLO, 32'd5, 1'b0);
        run_op("MADD_m2x3",  OP_MADD,  32'hFFFF_FFFE, 32'd3,        10, 64'hFFFF_FFFF_FFFF_FFFF);

        run_op("DIV_m7d2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,        33, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("DIVU_100d0", OP_DIVU,  32'd100, 32'd0,              33, 64'h0000_0064_FFFF_FFFF);
        run_op("DIV_m5d0",   OP_DIV,   32'hFFFF_FFFB, 32'd0,        33, 64'hFFFF_FFFB_FFFF_FFFF);
        run_op("DIV_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 64'h0000_0000_8000_0000);
        run_op("DIVU_100d7", OP_DIVU,  32'd100, 32'd7,              33, 64'h0000_0002_0000_000E);

        // MFHI issued right behind a MULT stalls until the new HI is available
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULT; bus.src_a = 32'h0001_0000; bus.src_b = 32'h0003_0000;
        @(negedge clk);
        bus.start = 1'b0; bus.rd_req = 1'b1; bus.rd_sel = 1'b1;
        cyc = 0; bad = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            #1 if (bus.stall !== 1'b1) bad++;
            cyc++;
            @(negedge clk);
        end
        check("mfhi_stall_held", 64'(bad), 64'd0);
        check("mfhi_busy_cycles", 64'(cyc), 64'd9);
        #1 check("mfhi_stall_release", 64'(bus.stall), 64'd0);
        check("mfhi_rd_data", 64'(bus.rd_data), 64'd3);
        bus.rd_req = 1'b0;
        $display("op MFHI_after_MULT stall_cycles=%0d rd_data=0x%08h", cyc, bus.rd_data);

        // Second issue while busy is held off until completion
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULTU; bus.src_a = 32'd7; bus.src_b = 32'd9;
        @(negedge clk);
        bus.op = OP_MTLO; bus.src_a = 32'h0000_5555;
        cyc = 0; bad = 0;
        while (bus.busy === 1'b1 && cyc < 100) begin
            #1 if (bus.stall !== 1'b1) bad++;
            cyc++;
            @(negedge clk);
        end
        check("issue_stall_held", 64'(bad), 64'd0);
        #1 check("issue_stall_release", 64'(bus.stall), 64'd0);
        bus.rd_sel = 1'b0;
        #1 check("issue_lo_before_mtlo", 64'(bus.rd_data), 64'd63);
        @(negedge clk);
        bus.start = 1'b0;
        read_hilo(hi, lo);
        check("issue_mtlo_after", {hi, lo}, 64'h0000_0000_0000_5555);
        check("issue_mtlo_nobusy", 64'(bus.busy), 64'd0);
        $display("op MTLO_after_busy HI=0x%08h LO=0x%08h", hi, lo);

        // Killed issue has no effect; MTHI takes one cycle without busy
        mt(OP_MTLO, 32'h0000_1234, 1'b1);
        check("kill_busy", 64'(bus.busy), 64'd0);
        read_hilo(hi, lo);
        check("kill_lo_unchanged", 64'(lo), 64'h5555);
        mt(OP_MTHI, 32'h0000_ABCD, 1'b0);
        check("mthi_busy", 64'(bus.busy), 64'd0);
        check("mthi_done", 64'(bus.done), 64'd0);
        read_hilo(hi, lo);
        check("mthi_hi", 64'(hi), 64'hABCD);

        // Asynchronous reset in cycle 5 of a DIV
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIV; bus.src_a = 32'd100; bus.src_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        reset_n = 1'b0;
        #1 check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        read_hilo(hi, lo);
        check("reset_hilo", {hi, lo}, 64'd0);
        $display("op RESET_mid_DIV busy=%0d HI=0x%08h LO=0x%08h", bus.busy, hi, lo);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("MULT_2x3",   OP_MULT,  32'd2, 32'd3,                9, 64'h0000_0000_0000_0006);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle HI/LO unit sequencer for the MIPS core. It accepts MULT/MULTU/MADD/MADDU/DIV/DIVU/MTHI/MTLO issues from the decoder/execute stage and runs an iterative shift-add multiplier or a restoring divider. It owns the HI/LO registers and generates pipeline stalls for MFHI/MFLO and for new issues while an operation is in flight.

Parameters:
MUL_BITS, 4, multiplier bits retired per cycle; legal values 1, 2, 4, 8; N_MUL = 32/MUL_BITS.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
start  in  1  issue request from execute stage
op  in  3  000 MULT, 001 MULTU, 010 MADD, 011 MADDU, 100 DIV, 101 DIVU, 110 MTHI, 111 MTLO
src_a  in  32  rs operand (dividend / multiplicand / MT data)
src_b  in  32  rt operand (divisor / multiplier)
kill  in  1  exception flush of the issuing instruction; same cycle as start
rd_req  in  1  MFHI/MFLO in execute
rd_sel  in  1  0 = LO, 1 = HI
rd_data  out  32  combinational mux of HI/LO by rd_sel
busy  out  1  registered; operation in flight
stall  out  1  combinational = busy & (start | rd_req)
done  out  1  registered single-cycle pulse when HI/LO update completes

Behaviour:
- Reset (async, reset_n=0): state IDLE, HI=0, LO=0, busy=0, done=0, all iteration registers 0. Reset mid-operation abandons it; HI/LO are not updated.
- Accept: start & ~busy & ~kill at edge T. start with kill, or start while busy: not accepted, no state change; stall holds the issuer while busy.
- MTHI/MTLO: HI or LO <= src_a at T; busy stays 0; done not pulsed.
- States: IDLE, MUL, DIV, FIX, ACC.
- IDLE -> MUL (mult ops) or DIV (div ops) on accept. Capture operands; signed ops (MULT, MADD, DIV) convert operands to magnitudes and record the result sign(s); unsigned ops take operands as-is.
- MUL: N_MUL cycles, each adds multiplicand*(next MUL_BITS multiplier bits) into a 64-bit product, LSB first -> FIX.
- DIV: exactly 32 cycles of restoring division, 1 quotient bit per cycle -> FIX.
- FIX: 1 cycle. Apply sign correction: product negated iff operand signs differ; quotient negated iff signs differ; remainder takes the dividend's sign. Non-accumulate ops write {HI,LO} (MUL: HI=product[63:32], LO=product[31:0]; DIV: LO=quotient, HI=remainder), pulse done and go to IDLE. MADD/MADDU -> ACC.
- ACC: 1 cycle. {HI,LO} <= {HI,LO} + product, modulo 2^64. Pulse done, go to IDLE.
- busy=1 in every non-IDLE state. Latency as busy-high cycles: MULT/MULTU N_MUL+1, MADD/MADDU N_MUL+2, DIV/DIVU 33. New HI/LO are visible on rd_data in the first cycle with busy=0.
- Divide by zero, either signedness: LO=0xFFFFFFFF, HI=src_a as captured. No trap; same 33-cycle latency.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wrap, no trap).
- HI/LO hold their value during an operation. rd_req while busy stalls until completion; rd_data is never used while stall=1.
- kill while busy has no effect; the in-flight operation completes.

Test Plan:
- MUL_BITS=4: MULT src_a=0xFFFFFFFD (-3), src_b=7 -> busy 9 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFEB, done pulsed once.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; MADDU 1*1 from HI=0, LO=0xFFFFFFFF -> HI=1, LO=0, busy 10 cycles.
- DIV -7/2 -> busy 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/0 -> LO=0xFFFFFFFF, HI=100.
- Issue MULT, then rd_req=1 rd_sel=1 on the next cycle -> stall=1 until busy falls; rd_data then equals the new HI. A second start while busy -> stall=1 and is accepted only after completion.
- start+kill with MTLO 0x1234 -> LO unchanged, busy stays 0. MTHI 0xABCD -> HI=0xABCD next cycle, no busy.
- reset_n low in cycle 5 of a DIV -> busy=0, HI=LO=0 immediately. After release, a new MULT 2*3 gives LO=6, HI=0.
